// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ write-domain producers.
// Optional statistics counters (stall_cnt, grant_cnt) are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         WrData,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   grant_cnt
`endif
);

    // state | meaning
    // IDLE  | no grant; picks the next requester after last_ptr, no write this cycle
    // BURST | grant held; one word per cycle while req[g] & ~wfull

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_REQ-1:0]     grant_nxt;
    logic [IDX_W-1:0]       gidx, gidx_nxt;
    logic [IDX_W-1:0]       last_ptr, last_ptr_nxt;
    logic [CNT_W-1:0]       burst_cnt, burst_cnt_nxt;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [DATA_WIDTH-1:0]  word [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts one past the last served requester so it is visited last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_ptr) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            burst_cnt <= '0;
            last_ptr  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            gidx      <= gidx_nxt;
            burst_cnt <= burst_cnt_nxt;
            last_ptr  <= last_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        gidx_nxt      = gidx;
        burst_cnt_nxt = burst_cnt;
        last_ptr_nxt  = last_ptr;
        busy          = (state == BURST);
        winc          = 1'b0;
        ack           = '0;
        WrData        = '0;

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt     = BURST;
                    gidx_nxt      = win_idx;
                    grant_nxt     = NUM_REQ'(1) << win_idx;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!req[gidx]) begin
                    // Drop wins over a concurrent wfull: release without writing.
                    state_nxt    = IDLE;
                    grant_nxt    = '0;
                    last_ptr_nxt = gidx;
                end else if (!wfull) begin
                    winc   = ~wrst;
                    ack    = grant & {NUM_REQ{~wrst}};
                    WrData = wrst ? '0 : word[gidx];
                    if (req_last[gidx] || (burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                        state_nxt    = IDLE;
                        grant_nxt    = '0;
                        last_ptr_nxt = gidx;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            if (busy && req[gidx] && wfull && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((state == IDLE) && win_found && (grant_cnt != 16'hFFFF)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end
`endif

    a_grant_onehot: assert property (@(posedge wclk) disable iff (wrst) $onehot0(grant));
    a_ack_onehot:   assert property (@(posedge wclk) disable iff (wrst) $onehot0(ack));
    a_winc_busy:    assert property (@(posedge wclk) disable iff (wrst) winc |-> busy);
    a_cnt_range:    assert property (@(posedge wclk) disable iff (wrst)
                                     burst_cnt <= CNT_W'(MAX_BURST - 1));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic             wclk = 1'b0;
    logic             wrst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic             wfull;
    logic             winc;
    logic [DW-1:0]    WrData;
    logic             busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]      stall_cnt;
    logic [15:0]      grant_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .wfull    (wfull),
        .winc     (winc),
        .WrData   (WrData),
        .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic [NR-1:0] q, input logic [NR*DW-1:0] d,
                         input logic [NR-1:0] l, input logic f);
        @(negedge wclk);
        wrst = r; req = q; req_data = d; req_last = l; wfull = f;
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [NR-1:0] q;
        logic [31:0]   d;
        logic [NR-1:0] l;
        logic          f;
        logic [NR-1:0] e_grant;
        logic          e_winc;
        logic [NR-1:0] e_ack;
        logic [DW-1:0] e_wd;
        logic          e_busy;
    } vec_t;

    vec_t vecs[18];

    // reference model state
    bit m_busy;
    int m_g, m_words, m_last, m_stall, m_grants;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  words [4];
        logic [7:0]  rx [$];
        int          ptr, stall_left, stalls_seen;
        bit          started, prev_full, done;
        logic [NR-1:0] e_grant, e_ack;
        logic        e_winc;
        logic [DW-1:0] e_wd;
        int          g;

        wrst = 1'b1; req = '0; req_data = '0; req_last = '0; wfull = 1'b0;

        vecs[0]  = '{1'b1, 4'hF, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'hF, 32'h44332211, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h44332211, 4'h0, 1'b0, 4'h1, 1'b0, 4'h0, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 4'h4, 32'h00A10000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 4'h4, 32'h00A10000, 4'h0, 1'b0, 4'h4, 1'b1, 4'h4, 8'hA1, 1'b1};
        vecs[6]  = '{1'b0, 4'h4, 32'h00A20000, 4'h0, 1'b0, 4'h4, 1'b1, 4'h4, 8'hA2, 1'b1};
        vecs[7]  = '{1'b0, 4'h4, 32'h00A30000, 4'h4, 1'b0, 4'h4, 1'b1, 4'h4, 8'hA3, 1'b1};
        vecs[8]  = '{1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 4'h2, 32'h0000B100, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 4'hA, 32'hC100B100, 4'h0, 1'b0, 4'h2, 1'b1, 4'h2, 8'hB1, 1'b1};
        vecs[11] = '{1'b0, 4'h8, 32'hC100B200, 4'h0, 1'b0, 4'h2, 1'b0, 4'h0, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 4'h8, 32'hC1000000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 4'h8, 32'hC1000000, 4'h8, 1'b0, 4'h8, 1'b1, 4'h8, 8'hC1, 1'b1};
        vecs[14] = '{1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 4'h1, 32'h000000D1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        vecs[16] = '{1'b0, 4'h0, 32'h000000D1, 4'h0, 1'b1, 4'h1, 1'b0, 4'h0, 8'h00, 1'b1};
        vecs[17] = '{1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].q, vecs[i].d, vecs[i].l, vecs[i].f);
            chk($sformatf("vec%0d_grant", i), 32'(grant),  32'(vecs[i].e_grant));
            chk($sformatf("vec%0d_winc", i),  32'(winc),   32'(vecs[i].e_winc));
            chk($sformatf("vec%0d_ack", i),   32'(ack),    32'(vecs[i].e_ack));
            chk($sformatf("vec%0d_wdata", i), 32'(WrData), 32'(vecs[i].e_wd));
            chk($sformatf("vec%0d_busy", i),  32'(busy),   32'(vecs[i].e_busy));
        end

        // All requesters busy: bursts of MB words to 0,1,2,3,0 with one idle cycle between.
        drive(1'b1, 4'hF, 32'h13121110, 4'h0, 1'b0);
        for (int c = 0; c < 22; c++) begin
            drive(1'b0, 4'hF, 32'h13121110, 4'h0, 1'b0);
            g = (c / (MB + 1)) % NR;
            if ((c % (MB + 1)) == 0) begin
                chk($sformatf("rr%0d_grant", c), 32'(grant), 32'h0);
                chk($sformatf("rr%0d_winc", c),  32'(winc),  32'h0);
            end else begin
                chk($sformatf("rr%0d_grant", c), 32'(grant),  32'(1 << g));
                chk($sformatf("rr%0d_winc", c),  32'(winc),   32'h1);
                chk($sformatf("rr%0d_wdata", c), 32'(WrData), 32'(8'h10 + g));
            end
        end

        // wfull for 5 cycles after the second word of a 4-word packet from requester 0.
        drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
        words[0] = 8'hE0; words[1] = 8'hE1; words[2] = 8'hE2; words[3] = 8'hE3;
        ptr = 0; stall_left = 0; stalls_seen = 0; started = 0; prev_full = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            drive(1'b0, {3'b000, ptr < 4}, {24'h0, words[ptr < 4 ? ptr : 3]},
                  {3'b000, ptr == 3}, stall_left > 0);
            if (wfull) begin
                stalls_seen++;
                chk("stall_winc", 32'(winc), 32'h0);
                chk("stall_ack",  32'(ack),  32'h0);
            end
            if (winc) begin
                rx.push_back(WrData);
                if (rx.size() == 3) chk("third_word_on_wfull_fall", 32'(prev_full), 32'h1);
            end
            prev_full = wfull;
            if (wfull) stall_left--;
            if (ack[0]) ptr++;
            if (ptr == 2 && !started) begin
                started = 1;
                stall_left = 5;
            end
            if (ptr == 4) done = 1;
        end
        chk("stall_seq_complete", 32'(done), 32'h1);
        chk("stall_cycles", 32'(stalls_seen), 32'd5);
        chk("stall_rx_count", 32'(rx.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            chk($sformatf("stall_rx%0d", i), 32'(rx[i]), 32'(8'hE0 + i));
        end
        drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        chk("stall_end_busy", 32'(busy), 32'h0);
`ifdef FIFO_ARB_STATS_EN
        chk("stats_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("stats_grant_cnt", 32'(grant_cnt), 32'd1);
`endif

        // Reset mid-burst: requester 1 is granted (0 was served last), reset after 2 words.
        drive(1'b0, 4'hF, 32'h13121110, 4'h0, 1'b0);
        chk("rst_arb_grant", 32'(grant), 32'h0);
        drive(1'b0, 4'hF, 32'h13121110, 4'h0, 1'b0);
        chk("rst_w1_grant", 32'(grant), 32'h2);
        chk("rst_w1_winc",  32'(winc),  32'h1);
        drive(1'b0, 4'hF, 32'h13121110, 4'h0, 1'b0);
        chk("rst_w2_winc",  32'(winc),  32'h1);
        drive(1'b1, 4'hF, 32'h13121110, 4'h0, 1'b0);
        chk("rst_cycle_winc", 32'(winc), 32'h0);
        chk("rst_cycle_ack",  32'(ack),  32'h0);
        drive(1'b0, 4'hF, 32'h13121110, 4'h0, 1'b0);
        chk("rst_after_grant", 32'(grant), 32'h0);
        chk("rst_after_winc",  32'(winc),  32'h0);
        chk("rst_after_busy",  32'(busy),  32'h0);
`ifdef FIFO_ARB_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
`endif
        drive(1'b0, 4'hF, 32'h13121110, 4'h0, 1'b0);
        chk("rst_restart_grant", 32'(grant), 32'h1);

        // Randomized traffic against the reference model.
        drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
        m_busy = 0; m_g = 0; m_words = 0; m_last = NR - 1; m_stall = 0; m_grants = 0;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(199) == 0, 4'($urandom) | 4'($urandom), $urandom,
                  4'($urandom) & 4'($urandom), $urandom_range(4) == 0);
            e_grant = m_busy ? NR'(1 << m_g) : '0;
            e_winc  = m_busy && req[m_g] && !wfull && !wrst;
            e_ack   = e_winc ? NR'(1 << m_g) : '0;
            e_wd    = e_winc ? req_data[m_g*DW +: DW] : '0;
            chk($sformatf("rand%0d {grant,winc,ack,wdata,busy}", c),
                32'({grant, winc, ack, WrData, busy}),
                32'({e_grant, e_winc, e_ack, e_wd, m_busy}));
`ifdef FIFO_ARB_STATS_EN
            chk($sformatf("rand%0d_stats", c), {stall_cnt, grant_cnt},
                {16'(m_stall), 16'(m_grants)});
`endif
            if (wrst) begin
                m_busy = 0; m_words = 0; m_last = NR - 1; m_stall = 0; m_grants = 0;
            end else if (!m_busy) begin
                if (req != '0) begin
                    for (int k = NR; k >= 1; k--) begin
                        if (req[(m_last + k) % NR]) m_g = (m_last + k) % NR;
                    end
                    m_busy = 1;
                    m_words = 0;
                    if (m_grants < 16'hFFFF) m_grants++;
                end
            end else if (!req[m_g]) begin
                m_busy = 0;
                m_last = m_g;
            end else if (wfull) begin
                if (m_stall < 16'hFFFF) m_stall++;
            end else begin
                m_words++;
                if (req_last[m_g] || m_words == MB) begin
                    m_busy = 0;
                    m_last = m_g;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
